// File: rtl/dmem_adapter_if.sv
// Word-wide data bus between the memory-stage adapter (master) and data memory (slave).
interface dmem_adapter_if;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic [31:0] bus_addr;
    logic        bus_we;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_resp_valid;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req_valid, bus_addr, bus_we, bus_be, bus_wdata,
        input  bus_req_ready, bus_resp_valid, bus_rdata
    );

    modport slave (
        input  bus_req_valid, bus_addr, bus_we, bus_be, bus_wdata,
        output bus_req_ready, bus_resp_valid, bus_rdata
    );
endinterface

// File: rtl/dmem_adapter.sv
// Turns byte/half/word memory-stage requests into aligned word bus accesses,
// stalls the pipeline while in flight and extends load data on completion.
module dmem_adapter (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic [31:0]           req_addr,
    input  logic                  req_fcn,
    input  logic [2:0]            req_typ,
    input  logic [31:0]           req_data,
    output logic                  resp_valid,
    output logic [31:0]           resp_data,
    output logic                  stall,
    output logic                  misaligned,
    output logic [31:0]           stall_cycles,
    dmem_adapter_if.master        bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [2:0] T_B  = 3'd1;
    localparam logic [2:0] T_H  = 3'd2;
    localparam logic [2:0] T_BU = 3'd5;
    localparam logic [2:0] T_HU = 3'd6;

    logic [1:0]  state;
    logic [31:0] addr_q;
    logic        we_q;
    logic [2:0]  typ_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [31:0] resp_data_q;

    logic        in_byte;
    logic        in_half;
    logic        in_misalign;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic        accept;
    logic        resp_fire;
    logic        in_req;
    logic [31:0] lane;
    logic [31:0] load_ext;

    // Unknown type codes (including MT_X) behave as full-word accesses.
    always_comb begin
        in_byte     = (req_typ == T_B) || (req_typ == T_BU);
        in_half     = (req_typ == T_H) || (req_typ == T_HU);
        be_d        = 4'b1111;
        wdata_d     = req_data;
        in_misalign = (req_addr[1:0] != 2'b00);
        if (in_byte) begin
            be_d        = 4'b0001 << req_addr[1:0];
            wdata_d     = {4{req_data[7:0]}};
            in_misalign = 1'b0;
        end else if (in_half) begin
            be_d        = req_addr[1] ? 4'b1100 : 4'b0011;
            wdata_d     = {2{req_data[15:0]}};
            in_misalign = req_addr[0];
        end
    end

    assign misaligned = (state == S_IDLE) && req_valid && in_misalign;
    assign accept     = (state == S_IDLE) && req_valid && !in_misalign;
    assign stall      = accept || (state == S_REQ) || (state == S_WAIT);
    assign resp_valid = (state == S_DONE);
    assign resp_data  = resp_data_q;

    // A response only counts in REQ when it arrives together with the handshake.
    assign resp_fire  = bus.bus_resp_valid &&
                        (((state == S_REQ) && bus.bus_req_ready) || (state == S_WAIT));

    always_comb begin
        lane = bus.bus_rdata >> {addr_q[1:0], 3'b000};
        case (typ_q)
            T_B:     load_ext = {{24{lane[7]}}, lane[7:0]};
            T_BU:    load_ext = {24'd0, lane[7:0]};
            T_H:     load_ext = {{16{lane[15]}}, lane[15:0]};
            T_HU:    load_ext = {16'd0, lane[15:0]};
            default: load_ext = lane;
        endcase
    end

    assign in_req            = (state == S_REQ);
    assign bus.bus_req_valid = in_req;
    assign bus.bus_addr      = in_req ? {addr_q[31:2], 2'b00} : 32'd0;
    assign bus.bus_we        = in_req && we_q;
    assign bus.bus_be        = in_req ? be_q : 4'd0;
    assign bus.bus_wdata     = in_req ? wdata_q : 32'd0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            addr_q       <= 32'd0;
            we_q         <= 1'b0;
            typ_q        <= 3'd0;
            be_q         <= 4'd0;
            wdata_q      <= 32'd0;
            resp_data_q  <= 32'd0;
            stall_cycles <= 32'd0;
        end else begin
            if (stall) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (resp_fire) begin
                resp_data_q <= we_q ? 32'd0 : load_ext;
            end
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        addr_q  <= req_addr;
                        we_q    <= req_fcn;
                        typ_q   <= req_typ;
                        be_q    <= be_d;
                        wdata_q <= wdata_d;
                        state   <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (bus.bus_req_ready) begin
                        state <= bus.bus_resp_valid ? S_DONE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.bus_resp_valid) begin
                        state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_adapter.sv
// Directed bench for dmem_adapter: hand-computed vectors checked with immediate assertions.
module tb_dmem_adapter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_fcn;
    logic [2:0]  req_typ;
    logic [31:0] req_data;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        stall;
    logic        misaligned;
    logic [31:0] stall_cycles;

    int checks   = 0;
    int failures = 0;

    dmem_adapter_if bus_if ();

    dmem_adapter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_fcn      (req_fcn),
        .req_typ      (req_typ),
        .req_data     (req_data),
        .resp_valid   (resp_valid),
        .resp_data    (resp_data),
        .stall        (stall),
        .misaligned   (misaligned),
        .stall_cycles (stall_cycles),
        .bus          (bus_if)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic v, input logic [31:0] a, input logic f,
                           input logic [2:0] t, input logic [31:0] d);
        req_valid = v;
        req_addr  = a;
        req_fcn   = f;
        req_typ   = t;
        req_data  = d;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        set_req(1'b0, 32'd0, 1'b0, 3'd0, 32'd0);
        bus_if.bus_req_ready  = 1'b0;
        bus_if.bus_resp_valid = 1'b0;
        bus_if.bus_rdata      = 32'd0;

        // Reset state
        tick();
        tick();
        check_output("rst_bus_req_valid", {31'd0, bus_if.bus_req_valid}, 32'd0);
        check_output("rst_bus_we", {31'd0, bus_if.bus_we}, 32'd0);
        check_output("rst_bus_be", {28'd0, bus_if.bus_be}, 32'd0);
        check_output("rst_bus_addr", bus_if.bus_addr, 32'd0);
        check_output("rst_bus_wdata", bus_if.bus_wdata, 32'd0);
        check_output("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check_output("rst_resp_data", resp_data, 32'd0);
        check_output("rst_stall_cycles", stall_cycles, 32'd0);
        check_output("rst_stall", {31'd0, stall}, 32'd0);
        check_output("rst_misaligned", {31'd0, misaligned}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Word load at 0x100, one-cycle ready and response
        $display("[TB] word load 0x100");
        set_req(1'b1, 32'h100, 1'b0, 3'd3, 32'd0);
        #1;
        check_output("w_c0_stall", {31'd0, stall}, 32'd1);
        check_output("w_c0_misaligned", {31'd0, misaligned}, 32'd0);
        check_output("w_c0_bus_req_valid", {31'd0, bus_if.bus_req_valid}, 32'd0);
        tick();
        bus_if.bus_req_ready = 1'b1;
        #1;
        check_output("w_c1_bus_req_valid", {31'd0, bus_if.bus_req_valid}, 32'd1);
        check_output("w_c1_bus_addr", bus_if.bus_addr, 32'h100);
        check_output("w_c1_bus_be", {28'd0, bus_if.bus_be}, 32'hF);
        check_output("w_c1_bus_we", {31'd0, bus_if.bus_we}, 32'd0);
        check_output("w_c1_stall", {31'd0, stall}, 32'd1);
        tick();
        bus_if.bus_req_ready  = 1'b0;
        bus_if.bus_resp_valid = 1'b1;
        bus_if.bus_rdata      = 32'hDEADBEEF;
        #1;
        check_output("w_c2_bus_req_valid", {31'd0, bus_if.bus_req_valid}, 32'd0);
        check_output("w_c2_stall", {31'd0, stall}, 32'd1);
        check_output("w_c2_resp_valid", {31'd0, resp_valid}, 32'd0);
        tick();
        bus_if.bus_resp_valid = 1'b0;
        #1;
        check_output("w_c3_resp_valid", {31'd0, resp_valid}, 32'd1);
        check_output("w_c3_resp_data", resp_data, 32'hDEADBEEF);
        check_output("w_c3_stall", {31'd0, stall}, 32'd0);
        check_output("w_c3_stall_cycles", stall_cycles, 32'd3);
        tick();
        req_valid = 1'b0;
        #1;
        check_output("w_idle_resp_valid", {31'd0, resp_valid}, 32'd0);
        check_output("w_idle_stall", {31'd0, stall}, 32'd0);

        // Signed byte load at 0x203, ready and response in the same cycle
        $display("[TB] byte load 0x203 B then BU");
        set_req(1'b1, 32'h203, 1'b0, 3'd1, 32'd0);
        bus_if.bus_rdata = 32'h80000000;
        #1;
        check_output("b_c0_stall", {31'd0, stall}, 32'd1);
        tick();
        bus_if.bus_req_ready  = 1'b1;
        bus_if.bus_resp_valid = 1'b1;
        #1;
        check_output("b_req_bus_be", {28'd0, bus_if.bus_be}, 32'h8);
        check_output("b_req_bus_addr", bus_if.bus_addr, 32'h200);
        tick();
        bus_if.bus_req_ready  = 1'b0;
        bus_if.bus_resp_valid = 1'b0;
        #1;
        check_output("b_done_resp_valid", {31'd0, resp_valid}, 32'd1);
        check_output("b_done_resp_data", resp_data, 32'hFFFFFF80);
        check_output("b_done_stall", {31'd0, stall}, 32'd0);
        check_output("b_done_stall_cycles", stall_cycles, 32'd5);
        // Back-to-back: unsigned byte accepted in the IDLE cycle after DONE
        tick();
        req_typ = 3'd5;
        #1;
        check_output("bu_c0_stall", {31'd0, stall}, 32'd1);
        check_output("bu_c0_bus_req_valid", {31'd0, bus_if.bus_req_valid}, 32'd0);
        tick();
        bus_if.bus_req_ready = 1'b1;
        #1;
        tick();
        bus_if.bus_req_ready  = 1'b0;
        bus_if.bus_resp_valid = 1'b1;
        #1;
        tick();
        bus_if.bus_resp_valid = 1'b0;
        #1;
        check_output("bu_done_resp_data", resp_data, 32'h00000080);
        check_output("bu_done_stall_cycles", stall_cycles, 32'd8);
        tick();
        req_valid = 1'b0;
        #1;
        check_output("bu_after_bus_req_valid", {31'd0, bus_if.bus_req_valid}, 32'd0);
        check_output("bu_after_stall", {31'd0, stall}, 32'd0);

        // Halfword store at 0x302
        $display("[TB] halfword store 0x302");
        set_req(1'b1, 32'h302, 1'b1, 3'd2, 32'h1234ABCD);
        bus_if.bus_rdata = 32'hFFFFFFFF;
        #1;
        check_output("hs_c0_stall", {31'd0, stall}, 32'd1);
        tick();
        bus_if.bus_req_ready = 1'b1;
        #1;
        check_output("hs_req_bus_we", {31'd0, bus_if.bus_we}, 32'd1);
        check_output("hs_req_bus_be", {28'd0, bus_if.bus_be}, 32'hC);
        check_output("hs_req_bus_wdata", bus_if.bus_wdata, 32'hABCDABCD);
        check_output("hs_req_bus_addr", bus_if.bus_addr, 32'h300);
        tick();
        bus_if.bus_req_ready  = 1'b0;
        bus_if.bus_resp_valid = 1'b1;
        #1;
        tick();
        bus_if.bus_resp_valid = 1'b0;
        #1;
        check_output("hs_done_resp_valid", {31'd0, resp_valid}, 32'd1);
        check_output("hs_done_resp_data", resp_data, 32'd0);
        check_output("hs_done_stall_cycles", stall_cycles, 32'd11);
        tick();
        req_valid = 1'b0;
        #1;

        // Signed halfword load from the upper half of 0x300
        $display("[TB] halfword load 0x302");
        set_req(1'b1, 32'h302, 1'b0, 3'd2, 32'd0);
        bus_if.bus_rdata = 32'h80011234;
        #1;
        tick();
        bus_if.bus_req_ready  = 1'b1;
        bus_if.bus_resp_valid = 1'b1;
        #1;
        check_output("hl_req_bus_be", {28'd0, bus_if.bus_be}, 32'hC);
        check_output("hl_req_bus_we", {31'd0, bus_if.bus_we}, 32'd0);
        tick();
        bus_if.bus_req_ready  = 1'b0;
        bus_if.bus_resp_valid = 1'b0;
        #1;
        check_output("hl_done_resp_data", resp_data, 32'hFFFF8001);
        check_output("hl_done_stall_cycles", stall_cycles, 32'd13);
        tick();
        req_valid = 1'b0;
        #1;

        // Misaligned requests are flagged and never issued
        $display("[TB] misaligned requests");
        set_req(1'b1, 32'h101, 1'b0, 3'd3, 32'd0);
        #1;
        check_output("mis_w_misaligned", {31'd0, misaligned}, 32'd1);
        check_output("mis_w_stall", {31'd0, stall}, 32'd0);
        tick();
        check_output("mis_w_bus_req_valid", {31'd0, bus_if.bus_req_valid}, 32'd0);
        req_typ = 3'd2;
        #1;
        check_output("mis_h_misaligned", {31'd0, misaligned}, 32'd1);
        check_output("mis_h_stall", {31'd0, stall}, 32'd0);
        tick();
        check_output("mis_h_bus_req_valid", {31'd0, bus_if.bus_req_valid}, 32'd0);
        req_addr = 32'h102;
        req_typ  = 3'd6;
        #1;
        check_output("mis_hu102_misaligned", {31'd0, misaligned}, 32'd0);
        req_typ = 3'd0;
        #1;
        check_output("mis_x102_misaligned", {31'd0, misaligned}, 32'd1);
        req_addr = 32'h103;
        req_typ  = 3'd5;
        #1;
        check_output("mis_bu103_misaligned", {31'd0, misaligned}, 32'd0);
        req_valid = 1'b0;
        #1;
        check_output("mis_novalid_misaligned", {31'd0, misaligned}, 32'd0);
        tick();
        check_output("mis_stall_cycles", stall_cycles, 32'd13);

        // Backpressure: ready withheld 4 cycles, WAIT lasts 3 cycles
        $display("[TB] backpressure word store 0x40C");
        set_req(1'b1, 32'h40C, 1'b1, 3'd0, 32'hCAFEF00D);
        bus_if.bus_rdata = 32'h55555555;
        #1;
        check_output("bp_c0_stall", {31'd0, stall}, 32'd1);
        tick();
        for (int i = 0; i < 4; i++) begin
            check_output("bp_hold_bus_req_valid", {31'd0, bus_if.bus_req_valid}, 32'd1);
            check_output("bp_hold_bus_addr", bus_if.bus_addr, 32'h40C);
            check_output("bp_hold_bus_be", {28'd0, bus_if.bus_be}, 32'hF);
            check_output("bp_hold_bus_wdata", bus_if.bus_wdata, 32'hCAFEF00D);
            check_output("bp_hold_stall", {31'd0, stall}, 32'd1);
            tick();
        end
        bus_if.bus_req_ready = 1'b1;
        #1;
        check_output("bp_hs_bus_addr", bus_if.bus_addr, 32'h40C);
        check_output("bp_hs_bus_wdata", bus_if.bus_wdata, 32'hCAFEF00D);
        tick();
        bus_if.bus_req_ready = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check_output("bp_wait_stall", {31'd0, stall}, 32'd1);
            check_output("bp_wait_bus_req_valid", {31'd0, bus_if.bus_req_valid}, 32'd0);
            check_output("bp_wait_resp_valid", {31'd0, resp_valid}, 32'd0);
            tick();
        end
        bus_if.bus_resp_valid = 1'b1;
        #1;
        tick();
        bus_if.bus_resp_valid = 1'b0;
        #1;
        check_output("bp_done_resp_valid", {31'd0, resp_valid}, 32'd1);
        check_output("bp_done_resp_data", resp_data, 32'd0);
        check_output("bp_done_stall_cycles", stall_cycles, 32'd22);
        tick();
        req_valid = 1'b0;
        #1;
        check_output("bp_after_resp_valid", {31'd0, resp_valid}, 32'd0);

        // Reset while waiting for the response, then a late response
        $display("[TB] reset in WAIT");
        set_req(1'b1, 32'h500, 1'b0, 3'd3, 32'd0);
        #1;
        tick();
        bus_if.bus_req_ready = 1'b1;
        #1;
        tick();
        bus_if.bus_req_ready = 1'b0;
        #1;
        check_output("rw_wait_stall", {31'd0, stall}, 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n                 = 1'b1;
        req_valid             = 1'b0;
        bus_if.bus_resp_valid = 1'b1;
        bus_if.bus_rdata      = 32'h12345678;
        #1;
        check_output("rw_bus_req_valid", {31'd0, bus_if.bus_req_valid}, 32'd0);
        check_output("rw_resp_valid", {31'd0, resp_valid}, 32'd0);
        check_output("rw_resp_data", resp_data, 32'd0);
        check_output("rw_stall", {31'd0, stall}, 32'd0);
        check_output("rw_stall_cycles", stall_cycles, 32'd0);
        check_output("rw_bus_be", {28'd0, bus_if.bus_be}, 32'd0);
        check_output("rw_bus_addr", bus_if.bus_addr, 32'd0);
        tick();
        bus_if.bus_resp_valid = 1'b0;
        #1;
        check_output("rw_late_resp_valid", {31'd0, resp_valid}, 32'd0);
        check_output("rw_late_resp_data", resp_data, 32'd0);
        check_output("rw_late_stall_cycles", stall_cycles, 32'd0);
        set_req(1'b1, 32'h500, 1'b0, 3'd3, 32'd0);
        #1;
        check_output("rw_new_accept_stall", {31'd0, stall}, 32'd1);
        req_valid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
